// File: rtl/zion_riscv_isa_lib_slt_arbiter.sv
// rtl/zion_riscv_isa_lib_slt_arbiter.sv - round-robin shared set-less-than comparator
module zion_riscv_isa_lib_slt_arbiter #(
  parameter  int RV64      = 0,
  parameter  int NUM_REQ   = 2,
  localparam int CPU_WIDTH = 32 * (RV64 + 1),
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             reqVld,
  output logic [NUM_REQ-1:0]             reqRdy,
  input  logic [NUM_REQ-1:0]             reqUnsigned,
  input  logic [NUM_REQ*CPU_WIDTH-1:0]   reqS1,
  input  logic [NUM_REQ*CPU_WIDTH-1:0]   reqS2,
  output logic                           rspVld,
  input  logic                           rspRdy,
  output logic [ID_W-1:0]                rspId,
  output logic                           rspLess
);

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_less_q, rsp_less_d;

  logic                 can_accept;
  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_id;
  logic                 handshake;
  logic [CPU_WIDTH-1:0] sel_s1, sel_s2;
  logic [CPU_WIDTH:0]   ext_s1, ext_s2;
  logic                 less;

  assign can_accept = rst_n & (~rsp_vld_q | rspRdy);

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && reqVld[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  assign handshake = can_accept & gnt_found;
  assign reqRdy    = handshake ? (NUM_REQ'(1) << gnt_id) : '0;

  // One extra bit makes a single signed compare serve both signednesses.
  assign sel_s1 = reqS1[gnt_id*CPU_WIDTH +: CPU_WIDTH];
  assign sel_s2 = reqS2[gnt_id*CPU_WIDTH +: CPU_WIDTH];
  assign ext_s1 = {~reqUnsigned[gnt_id] & sel_s1[CPU_WIDTH-1], sel_s1};
  assign ext_s2 = {~reqUnsigned[gnt_id] & sel_s2[CPU_WIDTH-1], sel_s2};
  assign less   = $signed(ext_s1) < $signed(ext_s2);

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_id_d   = rsp_id_q;
    rsp_less_d = rsp_less_q;
    if (handshake) begin
      rsp_vld_d  = 1'b1;
      rsp_id_d   = gnt_id;
      rsp_less_d = less;
      rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (rspRdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_less_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_less_q <= rsp_less_d;
    end
  end

  assign rspVld  = rsp_vld_q;
  assign rspId   = rsp_id_q;
  assign rspLess = rsp_less_q;

endmodule

// File: tb/tb_zion_riscv_isa_lib_slt_arbiter.sv
// tb/tb_zion_riscv_isa_lib_slt_arbiter.sv - scoreboard bench for the shared SLT arbiter
module tb_zion_riscv_isa_lib_slt_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  typedef struct packed {
    logic         uns;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
  } op_t;

  typedef struct packed {
    logic [1:0] id;
    logic       less;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req_vld, req_rdy, req_uns;
  logic [N*W-1:0] req_s1, req_s2;
  logic           rsp_vld, rsp_rdy, rsp_less;
  logic [1:0]     rsp_id;

  logic [1:0]     vld64, rdy64, uns64;
  logic [127:0]   s1_64, s2_64;
  logic           rsp_vld64, rsp_rdy64, rsp_less64;
  logic [0:0]     rsp_id64;

  zion_riscv_isa_lib_slt_arbiter #(.RV64(0), .NUM_REQ(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .reqVld(req_vld), .reqRdy(req_rdy),
    .reqUnsigned(req_uns), .reqS1(req_s1), .reqS2(req_s2),
    .rspVld(rsp_vld), .rspRdy(rsp_rdy), .rspId(rsp_id), .rspLess(rsp_less)
  );

  zion_riscv_isa_lib_slt_arbiter #(.RV64(1), .NUM_REQ(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .reqVld(vld64), .reqRdy(rdy64),
    .reqUnsigned(uns64), .reqS1(s1_64), .reqS2(s2_64),
    .rspVld(rsp_vld64), .rspRdy(rsp_rdy64), .rspId(rsp_id64), .rspLess(rsp_less64)
  );

  op_t  pend[N][$];
  exp_t sb[$];
  int   ptr_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_less(input op_t o);
    if (o.uns) return o.s1 < o.s2;
    return $signed(o.s1) < $signed(o.s2);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i] = (pend[i].size() > 0);
      if (pend[i].size() > 0) begin
        req_uns[i]        = pend[i][0].uns;
        req_s1[i*W +: W]  = pend[i][0].s1;
        req_s2[i*W +: W]  = pend[i][0].s2;
      end
    end
  endtask

  task automatic push_op(input int r, input logic uns, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.uns = uns; o.s1 = a; o.s2 = b;
    pend[r].push_back(o);
  endtask

  // One clock: check outputs and grant against the model, then advance.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int           g;
    exp_t         e;
    @(negedge clk);
    if (sb.size() > 0) begin
      chk("rsp_vld", 64'(rsp_vld), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
      chk("rsp_less", 64'(rsp_less), 64'(sb[0].less));
    end else begin
      chk("rsp_vld", 64'(rsp_vld), 64'd0);
    end
    exp_rdy = '0;
    g = -1;
    if (rst_n && (sb.size() == 0 || rsp_rdy)) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_vld[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    if (!rst_n) begin
      sb.delete();
      ptr_m = 0;
    end else begin
      if (sb.size() > 0 && rsp_rdy) void'(sb.pop_front());
      if (g >= 0) begin
        e.id   = 2'(g);
        e.less = model_less(pend[g][0]);
        sb.push_back(e);
        ptr_m = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) void'(pend[g].pop_front());
    drive();
  endtask

  task automatic run64(input logic uns, input logic [63:0] a, input logic [63:0] b, input logic exp);
    int n;
    n = 0;
    vld64 = 2'b01; uns64 = {1'b0, uns};
    s1_64 = {64'h0, a}; s2_64 = {64'h0, b};
    @(negedge clk);
    while (!rdy64[0] && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("rdy64", 64'(rdy64), 64'd1);
    @(posedge clk);
    #1 vld64 = 2'b00;
    @(negedge clk);
    chk("rsp_vld64", 64'(rsp_vld64), 64'd1);
    chk("rsp_id64", 64'(rsp_id64), 64'd0);
    chk("rsp_less64", 64'(rsp_less64), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0; rsp_rdy = 1'b1; ptr_m = 0;
    req_vld = '0; req_uns = '0; req_s1 = '0; req_s2 = '0;
    vld64 = '0; uns64 = '0; s1_64 = '0; s2_64 = '0; rsp_rdy64 = 1'b1;

    // Reset with requesters 0 and 1 already valid
    push_op(0, 1'b0, 32'd5, 32'd9);
    push_op(1, 1'b1, 32'd9, 32'd5);
    drive();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // Signedness
    push_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    push_op(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    push_op(0, 1'b0, 32'h8000_0000, 32'h8000_0000);
    push_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    push_op(0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
    drive();
    repeat (7) cycle();

    // Round-robin from a fresh pointer, then a lone requester 2
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        push_op(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    drive();
    repeat (8) cycle();
    for (int r = 0; r < 3; r++) push_op(2, 1'($urandom_range(0, 1)), $urandom, $urandom);
    drive();
    repeat (5) cycle();

    // Backpressure after one accept
    push_op(0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
    push_op(1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
    drive();
    cycle();
    rsp_rdy = 1'b0;
    repeat (4) cycle();
    rsp_rdy = 1'b1;
    repeat (4) cycle();

    // Reset while stalled drops the held result and restarts the pointer
    push_op(0, 1'b0, 32'd1, 32'd2);
    push_op(0, 1'b0, 32'd3, 32'd2);
    push_op(1, 1'b0, 32'hFFFF_FFFE, 32'd0);
    drive();
    cycle();
    rsp_rdy = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    repeat (5) cycle();

    // RV64 operands
    run64(1'b0, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    run64(1'b1, 64'h8000_0000_0000_0000, 64'h0, 1'b0);
    run64(1'b0, 64'h0, 64'h8000_0000_0000_0000, 1'b0);
    run64(1'b1, 64'h0, 64'h8000_0000_0000_0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
